// File: rtl/round_sequencer.sv
// Memory-game round sequencer: replays a growing LED pattern from a
// pattern ROM, then checks the user's key presses against it.
module round_sequencer #(
  parameter int unsigned P_ON_CYC      = 25000000,
  parameter int unsigned P_OFF_CYC     = 12500000,
  parameter int unsigned P_TIMEOUT_CYC = 250000000,
  parameter int unsigned P_MAX_LEVEL   = 16
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       start_i,
  input  logic [3:0] key_i,
  output logic [3:0] rom_addr_o,
  input  logic [3:0] rom_data_i,
  output logic [3:0] led_o,
  output logic [4:0] level_o,
  output logic       user_turn_o,
  output logic       win_o,
  output logic       lose_o,
  output logic [3:0] state_o
);

  localparam int unsigned C_A =
    (P_ON_CYC > P_OFF_CYC) ? P_ON_CYC : P_OFF_CYC;
  localparam int unsigned C_MAX =
    (C_A > P_TIMEOUT_CYC) ? C_A : P_TIMEOUT_CYC;
  localparam int unsigned CW = $clog2(C_MAX + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(P_ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(P_OFF_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(P_TIMEOUT_CYC - 1);
  localparam logic [4:0]    MAX_LVL  = 5'(P_MAX_LEVEL);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_SHOW_ON   = 4'd2,
    S_SHOW_OFF  = 4'd3,
    S_FETCH     = 4'd4,
    S_WAIT_IN   = 4'd5,
    S_ROUND_GAP = 4'd6,
    S_WIN       = 4'd7,
    S_LOSE      = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    level_q, level_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sub_q, sub_d;
  logic [3:0]    key_prev_q, key_prev_d;
  logic [3:0]    led_q, led_d;
  logic          ut_q, ut_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;

  logic       press;
  logic       match;
  logic [3:0] pressed;
  logic [4:0] idx_inc;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    level_d    = level_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    sub_d      = sub_q;
    key_prev_d = key_i;
    pressed    = ~key_i;
    idx_inc    = {1'b0, idx_q} + 5'd1;
    // A press is the released-to-pressed edge, seen only while waiting.
    press      = (state_q == S_WAIT_IN) && (key_i != 4'hF)
                 && (key_prev_q == 4'hF);
    match      = (pressed == pat_q) && $onehot(pressed);

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_i) begin
          state_d = S_LOAD;
          level_d = 5'd1;
          idx_d   = 4'd0;
          sub_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_LOAD, S_FETCH: begin
        if (!sub_q) begin
          sub_d = 1'b1;
        end else begin
          sub_d   = 1'b0;
          pat_d   = rom_data_i;
          cnt_d   = '0;
          state_d = (state_q == S_LOAD) ? S_SHOW_ON : S_WAIT_IN;
        end
      end
      S_SHOW_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (idx_inc == level_q) begin
            idx_d   = 4'd0;
            state_d = S_FETCH;
          end else begin
            idx_d   = idx_inc[3:0];
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IN: begin
        if (press) begin
          cnt_d = '0;
          if (!match) begin
            state_d = S_LOSE;
          end else if (idx_inc < level_q) begin
            idx_d   = idx_inc[3:0];
            state_d = S_FETCH;
          end else if (level_q >= MAX_LVL) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 5'd1;
            idx_d   = 4'd0;
            state_d = S_ROUND_GAP;
          end
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          state_d = S_LOSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ROUND_GAP: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d   = '0;
          sub_d   = 1'b0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs follow the next state so they line up with state_o.
    led_d  = (state_d == S_SHOW_ON) ? pat_d : 4'd0;
    ut_d   = (state_d == S_FETCH) || (state_d == S_WAIT_IN);
    win_d  = (state_d == S_WIN);
    lose_d = (state_d == S_LOSE);
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      level_q    <= 5'd1;
      pat_q      <= 4'd0;
      cnt_q      <= '0;
      sub_q      <= 1'b0;
      key_prev_q <= 4'hF;
      led_q      <= 4'd0;
      ut_q       <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      key_prev_q <= key_prev_d;
      led_q      <= led_d;
      ut_q       <= ut_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign rom_addr_o  = idx_q;
  assign state_o     = state_q;
  assign led_o       = led_q;
  assign level_o     = level_q;
  assign user_turn_o = ut_q;
  assign win_o       = win_q;
  assign lose_o      = lose_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: stimulus queues expected state
// entries and dwell times, a monitor checks every cycle.
module tb_round_sequencer;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_ON   = 4'd2;
  localparam logic [3:0] S_OFF  = 4'd3;
  localparam logic [3:0] S_FET  = 4'd4;
  localparam logic [3:0] S_WAIT = 4'd5;
  localparam logic [3:0] S_GAP  = 4'd6;
  localparam logic [3:0] S_WIN  = 4'd7;
  localparam logic [3:0] S_LOSE = 4'd8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [3:0] key_i;
  logic [3:0] rom_addr_o;
  logic [3:0] rom_data_i;
  logic [3:0] led_o;
  logic [4:0] level_o;
  logic       user_turn_o;
  logic       win_o;
  logic       lose_o;
  logic [3:0] state_o;

  round_sequencer #(
    .P_ON_CYC(4), .P_OFF_CYC(2),
    .P_TIMEOUT_CYC(20), .P_MAX_LEVEL(2)
  ) dut (
    .clock_50(clk), .reset(reset), .start_i(start_i),
    .key_i(key_i), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .led_o(led_o), .level_o(level_o),
    .user_turn_o(user_turn_o), .win_o(win_o), .lose_o(lose_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [3:0] rom [16];
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b1000;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
  end
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] led;
    logic [4:0] lvl;
    logic       ut;
    logic       win;
    logic       lose;
  } obs_t;

  typedef struct {
    obs_t o;
    int   dur;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  function automatic obs_t mk(input logic [3:0] st, input logic [3:0] led,
                              input logic [4:0] lvl, input logic ut,
                              input logic w, input logic l);
    obs_t o;
    o.st = st; o.led = led; o.lvl = lvl;
    o.ut = ut; o.win = w; o.lose = l;
    return o;
  endfunction

  task automatic push(input obs_t o, input int dur);
    exp_t e;
    e.o = o;
    e.dur = dur;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    checks++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state_o == s) return;
    end
    fails++;
    $display("FAIL wait_state: got state %0d expected %0d", state_o, s);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  // Expected display sequence of one level, ending in WAIT_IN.
  task automatic exp_show(input int lvl, input int first_dur);
    logic [4:0] l;
    l = 5'(lvl);
    push(mk(S_LOAD, 4'd0, l, 0, 0, 0), first_dur);
    for (int i = 0; i < lvl; i++) begin
      push(mk(S_ON, rom[i], l, 0, 0, 0), 2);
      push(mk(S_OFF, 4'd0, l, 0, 0, 0), 4);
      if (i < lvl - 1) push(mk(S_LOAD, 4'd0, l, 0, 0, 0), 2);
      else push(mk(S_FET, 4'd0, l, 1, 0, 0), 2);
    end
    push(mk(S_WAIT, 4'd0, l, 1, 0, 0), 2);
  endtask

  // Press on WAIT_IN cycle m+1, then release the following cycle.
  task automatic press(input logic [3:0] k, input int m, input obs_t nxt);
    push(nxt, m + 1);
    wait_state(S_WAIT, 200);
    repeat (m) @(negedge clk);
    key_i = k;
    @(negedge clk) key_i = 4'hF;
  endtask

  initial begin : monitor
    obs_t       cur, act;
    logic [3:0] prev;
    int         dwell;
    exp_t       e;
    wait (mon_en);
    prev  = state_o;
    dwell = 0;
    cur   = mk(S_IDLE, 4'd0, 5'd1, 0, 0, 0);
    forever begin
      @(negedge clk);
      act = {state_o, led_o, level_o, user_turn_o, win_o, lose_o};
      if (state_o !== prev) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL transition: state %0d -> %0d not expected",
                   prev, state_o);
          cur = act;
        end else begin
          e = q.pop_front();
          if (e.dur >= 0) begin
            checks++;
            if (dwell != e.dur) begin
              fails++;
              $display("FAIL dwell: state %0d lasted %0d cycles, expected %0d",
                       prev, dwell, e.dur);
            end
          end
          cur = e.o;
        end
        prev  = state_o;
        dwell = 1;
      end else begin
        dwell++;
      end
      checks++;
      if (act !== cur) begin
        fails++;
        $display("FAIL outputs @%0t: st=%0d led=%b lvl=%0d ut=%b w=%b l=%b, expected st=%0d led=%b lvl=%0d ut=%b w=%b l=%b",
                 $time, act.st, act.led, act.lvl, act.ut, act.win, act.lose,
                 cur.st, cur.led, cur.lvl, cur.ut, cur.win, cur.lose);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset   = 1'b1;
    start_i = 1'b0;
    key_i   = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state_o), 32'(S_IDLE));
    chk("reset_outs", {led_o, level_o, user_turn_o, win_o, lose_o, rom_addr_o},
        {4'd0, 5'd1, 3'b000, 4'd0});
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Full game to WIN; start during SHOW_ON is ignored.
    exp_show(1, -1);
    pulse_start();
    wait_state(S_ON, 50);
    pulse_start();
    press(4'b1110, 2, mk(S_GAP, 4'd0, 5'd2, 0, 0, 0));
    exp_show(2, 2);
    press(4'b1110, 2, mk(S_FET, 4'd0, 5'd2, 1, 0, 0));
    push(mk(S_WAIT, 4'd0, 5'd2, 1, 0, 0), 2);
    press(4'b1011, 2, mk(S_WIN, 4'd0, 5'd2, 0, 1, 0));
    repeat (4) @(negedge clk);
    key_i = 4'b1110;
    @(negedge clk) key_i = 4'hF;
    repeat (5) @(negedge clk);

    // Wrong key, then two keys.
    exp_show(1, -1);
    pulse_start();
    press(4'b1101, 0, mk(S_LOSE, 4'd0, 5'd1, 0, 0, 1));
    exp_show(1, -1);
    pulse_start();
    press(4'b1100, 4, mk(S_LOSE, 4'd0, 5'd1, 0, 0, 1));

    // Timeout with no press.
    exp_show(1, -1);
    pulse_start();
    push(mk(S_LOSE, 4'd0, 5'd1, 0, 0, 1), 20);
    wait_state(S_LOSE, 100);

    // Press on the timeout cycle wins; press on cycle 19 restarts window.
    exp_show(1, -1);
    pulse_start();
    press(4'b1110, 19, mk(S_GAP, 4'd0, 5'd2, 0, 0, 0));
    exp_show(2, 2);
    press(4'b1110, 18, mk(S_FET, 4'd0, 5'd2, 1, 0, 0));
    push(mk(S_WAIT, 4'd0, 5'd2, 1, 0, 0), 2);
    push(mk(S_LOSE, 4'd0, 5'd2, 0, 0, 1), 20);
    wait_state(S_LOSE, 100);

    // Reset during a level-2 SHOW_ON.
    exp_show(1, -1);
    pulse_start();
    press(4'b1110, 0, mk(S_GAP, 4'd0, 5'd2, 0, 0, 0));
    push(mk(S_LOAD, 4'd0, 5'd2, 0, 0, 0), 2);
    push(mk(S_ON, rom[0], 5'd2, 0, 0, 0), 2);
    push(mk(S_IDLE, 4'd0, 5'd1, 0, 0, 0), 2);
    wait_state(S_ON, 50);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("reset_mid_show", {state_o, led_o, level_o},
        {S_IDLE, 4'd0, 5'd1});
    repeat (5) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
